// File: rtl/mips_pkg.sv
// Shared widths, load-size encodings and the MEM/WB bundle.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
    logic              to_reg;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        ld_size;
    logic              ld_signed;
  } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// Sub-word load lane select and sign/zero extension.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        ld_signed,
  output logic [31:0] val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    val = rdata;
    unique case (1'b1)
      (size == LD_BYTE):
        val = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      (size == LD_HALF):
        val = {{16{ld_signed & half_sel[15]}}, half_sel};
      default:
        val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and retire counter.
// Sub-word load extension is built only with MEM_WB_LOAD_EXT_EN defined.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_signed,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_val,
  output logic              wb_en,
  output logic              wb_valid,
  output logic [31:0]       retire_cnt
);

  mem_wb_t     r_q, r_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] ld_val;

  always_comb begin
    r_d          = r_q;
    retire_cnt_d = retire_cnt_q;
    priority case (1'b1)
      flush: r_d.valid = 1'b0;
      stall: r_d = r_q;
      default: begin
        r_d.valid     = mem_valid;
        r_d.dest      = mem_dest;
        r_d.wb_en     = mem_wb_en;
        r_d.to_reg    = mem_to_reg;
        r_d.alu_res   = mem_alu_res;
        r_d.rdata     = mem_rdata;
        r_d.ld_size   = mem_ld_size;
        r_d.ld_signed = mem_ld_signed;
        if (mem_valid)
          retire_cnt_d = retire_cnt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q          <= '0;
      retire_cnt_q <= '0;
    end else begin
      r_q          <= r_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef MEM_WB_LOAD_EXT_EN
  load_extend u_load_extend (
    .rdata     (r_q.rdata),
    .off       (r_q.alu_res[1:0]),
    .size      (r_q.ld_size),
    .ld_signed (r_q.ld_signed),
    .val       (ld_val)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{r_q.ld_size, r_q.ld_signed};
  assign ld_val    = r_q.rdata;
`endif

  // dest 0 is hardwired zero, so never raise a write for it
  assign wb_en      = r_q.valid & r_q.wb_en & (r_q.dest != '0);
  assign wb_valid   = r_q.valid;
  assign wb_dest    = r_q.dest;
  assign wb_val     = r_q.to_reg ? ld_val : r_q.alu_res;
  assign retire_cnt = retire_cnt_q;

endmodule
